// File: rtl/crc_frame_sequencer.sv
// Frame sequencer for the byte-wide CRC-32 engine: payload pass-through,
// zero padding to a minimum length, FCS append and inter-frame gap.
module crc_frame_sequencer #(
    parameter int MIN_FRAME_BYTES = 60,
    parameter int GAP_CYCLES      = 12,
    parameter int CNT_W           = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_last,
    input  logic        out_ready,
    output logic [7:0]  crc_data,
    output logic        crc_en,
    output logic        crc_clr,
    input  logic [31:0] crc_value,
    input  logic        crc_valid,
    output logic        busy,
    output logic        frame_done,
    output logic        crc_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PAYLOAD,
        S_PAD,
        S_WAIT_CRC,
        S_FCS,
        S_GAP
    } state_t;

    localparam logic [CNT_W:0] MIN_W   = (CNT_W+1)'(MIN_FRAME_BYTES);
    localparam logic [7:0]     GAP_END = 8'(GAP_CYCLES - 1);

    state_t         state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [1:0]     idx;
    logic [7:0]     gap_cnt;
    logic [31:0]    fcs_reg;

    logic [CNT_W:0] cnt_p1;
    logic           need_pad;
    logic           in_xfer;

    // Unsaturated count+1 so the pad decision is exact even at all-ones
    assign cnt_p1   = {1'b0, cnt} + (CNT_W+1)'(1);
    assign need_pad = cnt_p1 < MIN_W;
    assign in_xfer  = in_valid & out_ready & ~rst;
    assign busy     = state != S_IDLE;

    always_comb begin
        state_nx   = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_data   = 8'h00;
        out_last   = 1'b0;
        crc_data   = in_data;
        crc_en     = 1'b0;
        crc_clr    = 1'b0;
        frame_done = 1'b0;
        unique case (state)
            S_IDLE, S_PAYLOAD: begin
                in_ready  = out_ready & ~rst;
                out_valid = in_valid & ~rst;
                out_data  = in_data;
                crc_en    = in_xfer;
                crc_clr   = (state == S_IDLE) & ~in_xfer;
                if (in_xfer) begin
                    if (!in_last)
                        state_nx = S_PAYLOAD;
                    else if (need_pad)
                        state_nx = S_PAD;
                    else
                        state_nx = S_WAIT_CRC;
                end
            end
            S_PAD: begin
                out_valid = 1'b1;
                crc_data  = 8'h00;
                crc_en    = out_ready;
                if (out_ready && cnt_p1 >= MIN_W)
                    state_nx = S_WAIT_CRC;
            end
            S_WAIT_CRC: begin
                state_nx = S_FCS;
            end
            S_FCS: begin
                out_valid = 1'b1;
                out_data  = fcs_reg[{idx, 3'b000} +: 8];
                out_last  = idx == 2'd3;
                if (out_ready && idx == 2'd3) begin
                    frame_done = 1'b1;
                    state_nx   = S_GAP;
                end
            end
            S_GAP: begin
                crc_clr = 1'b1;
                if (gap_cnt == GAP_END)
                    state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            idx     <= 2'd0;
            gap_cnt <= 8'd0;
            fcs_reg <= 32'd0;
            crc_err <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_GAP)
                cnt <= '0;
            else if (crc_en && !(&cnt))
                cnt <= cnt + CNT_W'(1);
            if (state == S_WAIT_CRC)
                idx <= 2'd0;
            else if (state == S_FCS && out_ready)
                idx <= idx + 2'd1;
            if (state == S_GAP)
                gap_cnt <= gap_cnt + 8'd1;
            else
                gap_cnt <= 8'd0;
            if (state == S_WAIT_CRC) begin
                fcs_reg <= crc_value;
                if (!crc_valid)
                    crc_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_crc_frame_sequencer.sv
// Bench for crc_frame_sequencer: two instances (no padding / 60-byte minimum)
// each attached to a behavioural CRC-32 engine, checked against a frame model.
module tb_crc_frame_sequencer;

    localparam int GAP = 12;
    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0][7:0]  in_data, out_data, crc_data;
    logic [1:0]       in_valid, in_last, in_ready;
    logic [1:0]       out_valid, out_last, out_ready;
    logic [1:0]       crc_en, crc_clr, crc_valid;
    logic [1:0][31:0] crc_value;
    logic [1:0]       busy, frame_done, crc_err;

    crc_frame_sequencer #(.MIN_FRAME_BYTES(0), .GAP_CYCLES(GAP)) u_dut0 (
        .clk(clk), .rst(rst),
        .in_data(in_data[0]), .in_valid(in_valid[0]), .in_last(in_last[0]),
        .in_ready(in_ready[0]),
        .out_data(out_data[0]), .out_valid(out_valid[0]),
        .out_last(out_last[0]), .out_ready(out_ready[0]),
        .crc_data(crc_data[0]), .crc_en(crc_en[0]), .crc_clr(crc_clr[0]),
        .crc_value(crc_value[0]), .crc_valid(crc_valid[0]),
        .busy(busy[0]), .frame_done(frame_done[0]), .crc_err(crc_err[0])
    );

    crc_frame_sequencer #(.MIN_FRAME_BYTES(60), .GAP_CYCLES(GAP)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_data(in_data[1]), .in_valid(in_valid[1]), .in_last(in_last[1]),
        .in_ready(in_ready[1]),
        .out_data(out_data[1]), .out_valid(out_valid[1]),
        .out_last(out_last[1]), .out_ready(out_ready[1]),
        .crc_data(crc_data[1]), .crc_en(crc_en[1]), .crc_clr(crc_clr[1]),
        .crc_value(crc_value[1]), .crc_valid(crc_valid[1]),
        .busy(busy[1]), .frame_done(frame_done[1]), .crc_err(crc_err[1])
    );

    function automatic logic [31:0] crc_step(logic [31:0] c, logic [7:0] b);
        c = c ^ {24'd0, b};
        for (int i = 0; i < 8; i++)
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    // Behavioural engines: registered CRC, cleared by crc_clr
    logic [1:0][31:0] eng;
    logic [1:0]       seen, kill;
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (crc_clr[i]) begin
                eng[i]  <= 32'hFFFFFFFF;
                seen[i] <= 1'b0;
            end else if (crc_en[i]) begin
                eng[i]  <= crc_step(eng[i], crc_data[i]);
                seen[i] <= 1'b1;
            end
        end
    end
    assign crc_value[0] = ~eng[0];
    assign crc_value[1] = ~eng[1];
    assign crc_valid    = seen & ~kill;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor for the selected instance
    int   sel = 0;
    bq_t  oq;
    int   en_cnt, fd_cnt, last_cnt, last_pos, clr_en_bad = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid[sel] && out_ready[sel]) begin
                oq.push_back(out_data[sel]);
                if (out_last[sel]) begin
                    last_cnt++;
                    last_pos = oq.size() - 1;
                end
            end
            if (crc_en[sel]) en_cnt++;
            if (frame_done[sel]) fd_cnt++;
            if (|(crc_clr & crc_en)) clr_en_bad++;
        end
    end

    function automatic bq_t expect_frame(bq_t pl, int min);
        bq_t f = pl;
        logic [31:0] c = 32'hFFFFFFFF;
        while (f.size() < min) f.push_back(8'h00);
        foreach (f[i]) c = crc_step(c, f[i]);
        c = ~c;
        for (int b = 0; b < 4; b++) f.push_back(c[8*b +: 8]);
        return f;
    endfunction

    task automatic send_payload(input int s, input bq_t pl, input int stall);
        int k = 0;
        int cyc = 0;
        sel = s;
        oq.delete();
        en_cnt = 0; fd_cnt = 0; last_cnt = 0; last_pos = -1;
        while (k < pl.size() && cyc < 3000) begin
            @(posedge clk); #1;
            in_valid[s]  = 1'b1;
            in_data[s]   = pl[k];
            in_last[s]   = (k == pl.size() - 1);
            out_ready[s] = ($urandom_range(99) >= stall);
            @(negedge clk);
            if (in_ready[s]) k++;
            cyc++;
        end
        check("payload_timeout", k, pl.size());
    endtask

    task automatic finish_frame(input int s, input int stall);
        int cyc = 0;
        int g = 0;
        bit done = 0;
        @(posedge clk); #1;
        in_valid[s] = 1'b0;
        in_last[s]  = 1'b0;
        while (!done && cyc < 3000) begin
            out_ready[s] = ($urandom_range(99) >= stall);
            @(negedge clk);
            done = frame_done[s];
            cyc++;
            @(posedge clk); #1;
        end
        check("fcs_timeout", done, 1);
        out_ready[s] = 1'b1;
        @(negedge clk);
        while (!in_ready[s] && g < 100) begin
            g++;
            @(negedge clk);
        end
        check("gap_cycles", g, GAP);
    endtask

    task automatic run_frame(input string tag, input int s, input bq_t pl,
                             input int stall, input bq_t exp, input int pads,
                             input logic exp_err);
        send_payload(s, pl, stall);
        finish_frame(s, stall);
        check({tag, "_len"}, oq.size(), exp.size());
        foreach (exp[i])
            if (i < oq.size())
                check($sformatf("%s_b%0d", tag, i), oq[i], exp[i]);
        check({tag, "_last_cnt"}, last_cnt, 1);
        check({tag, "_last_pos"}, last_pos, exp.size() - 1);
        check({tag, "_done_cnt"}, fd_cnt, 1);
        check({tag, "_crc_en"}, en_cnt, pl.size() + pads);
        check({tag, "_crc_err"}, crc_err[s], exp_err);
    endtask

    bq_t msg, lit, pl, ex;
    int  len, pads;

    initial begin
        rst = 1'b1;
        in_valid = '0; in_last = '0; in_data = '0;
        out_ready = '0; kill = '0;
        msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        lit = msg;
        lit.push_back(8'h26); lit.push_back(8'h39);
        lit.push_back(8'hF4); lit.push_back(8'hCB);
        #1;
        check("rst_in_ready", in_ready, 2'b00);
        check("rst_out_valid", out_valid, 2'b00);
        check("rst_busy", busy, 2'b00);
        check("rst_crc_clr", crc_clr, 2'b11);
        check("rst_crc_err", crc_err, 2'b00);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        run_frame("std", 0, msg, 0, lit, 0, 1'b0);

        pl = '{8'($urandom)};
        run_frame("single", 0, pl, 0, expect_frame(pl, 0), 0, 1'b0);

        for (int f = 0; f < 3; f++) begin
            len = $urandom_range(20, 1);
            pl.delete();
            for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
            run_frame($sformatf("b2b%0d", f), 0, pl, 30,
                      expect_frame(pl, 0), 0, 1'b0);
        end

        pl.delete();
        for (int i = 0; i < 42; i++) pl.push_back(8'($urandom));
        ex = expect_frame(pl, 60);
        run_frame("arp", 1, pl, 0, ex, 18, 1'b0);
        run_frame("arp_stall", 1, pl, 40, ex, 18, 1'b0);

        pl.delete();
        for (int i = 0; i < 70; i++) pl.push_back(8'($urandom));
        run_frame("long", 1, pl, 20, expect_frame(pl, 60), 0, 1'b0);

        pl.delete();
        len = $urandom_range(59, 1);
        for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
        pads = 60 - len;
        kill[1] = 1'b1;
        run_frame("crc_err", 1, pl, 10, expect_frame(pl, 60), pads, 1'b1);
        kill[1] = 1'b0;

        in_data[0] = 8'h00;
        send_payload(0, msg, 0);
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        in_last[0]  = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_idx2", out_data[0], 8'hF4);
        check("pre_rst_last", out_last[0], 1'b0);
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", out_valid[0], 1'b0);
        check("arst_out_last", out_last[0], 1'b0);
        check("arst_busy", busy[0], 1'b0);
        check("arst_crc_clr", crc_clr[0], 1'b1);
        check("arst_in_ready", in_ready[0], 1'b0);
        check("arst_crc_err1", crc_err[1], 1'b0);
        check("arst_fd_cnt", fd_cnt, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_frame("after_rst", 0, msg, 0, lit, 0, 1'b0);

        check("clr_en_overlap", clr_en_bad, 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
